// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame constants and the baud divisor rounding.
// Optional even-parity support elsewhere is gated by UART_RX_PARITY_EN.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Rounded clk_freq / (16 * baud_rate), never below 1.
    function automatic int uart_div(input int clk_freq, input int baud_rate);
        int d;
        d = (clk_freq + 8 * baud_rate) / (UART_OVERSAMPLE * baud_rate);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-stream interface out of the UART receiver: valid/ready plus per-frame error pulses.
// parity_err is only meaningful when built with UART_RX_PARITY_EN.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      overrun;
    logic                      parity_err;

    modport master (output rx_data, rx_valid, frame_err, overrun, parity_err, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, parity_err, output rx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator; counter is held at zero while en is low so ticks
// line up with the start edge. Shared between receiver and transmitter.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int clk_freq  = 50000000,
    parameter int baud_rate = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int DIV = uart_div(clk_freq, baud_rate);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (cnt == TERM)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = en && (cnt == TERM);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, valid/ready output and framing/overrun pulses.
// Define UART_RX_PARITY_EN to receive an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_freq  = 50000000,
    parameter int baud_rate = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    uart_rx_if.master  rx
);

    localparam logic [3:0] MID_BIT  = 4'(UART_OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_SMP = 4'(UART_OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0]                sync;
    logic                      rxd_s;
    logic                      rxd_q;
    uart_state_t               state;
    logic [3:0]                scnt;
    logic [2:0]                bcnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      byte_done;
    logic                      tick;
    logic                      tick_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            rxd_q <= 1'b1;
        end else begin
            sync  <= {sync[0], rxd};
            rxd_q <= sync[1];
        end
    end

    assign rxd_s   = sync[1];
    assign tick_en = (state != ST_IDLE);

    uart_baud_tick #(
        .clk_freq  (clk_freq),
        .baud_rate (baud_rate)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            scnt         <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            byte_done    <= 1'b0;
            rx.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad       <= 1'b0;
            rx.parity_err <= 1'b0;
`endif
        end else begin
            byte_done    <= 1'b0;
            rx.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx.parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rxd_q && !rxd_s) begin
                        state <= ST_START;
                        scnt  <= '0;
                        bcnt  <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (scnt == MID_BIT) begin
                            scnt  <= '0;
                            state <= rxd_s ? ST_IDLE : ST_DATA;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                // scnt wraps 15 -> 0 naturally, so each sample lands mid-bit.
                ST_DATA: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == LAST_SMP) begin
                            shreg <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
                            bcnt  <= bcnt + 3'd1;
                            if (bcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == LAST_SMP) begin
                            par_bad <= rxd_s ^ (^shreg);
                            state   <= ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == LAST_SMP) begin
                            state        <= ST_IDLE;
                            rx.frame_err <= !rxd_s;
`ifdef UART_RX_PARITY_EN
                            rx.parity_err <= par_bad;
                            byte_done     <= rxd_s && !par_bad;
`else
                            byte_done     <= rxd_s;
`endif
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign rx.parity_err = 1'b0;
`endif

    // A consume in the same cycle as a new byte frees the slot, so no overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            rx.overrun  <= 1'b0;
        end else begin
            rx.overrun <= 1'b0;
            if (byte_done && (!rx.rx_valid || rx.rx_ready)) begin
                rx.rx_data  <= shreg;
                rx.rx_valid <= 1'b1;
            end else begin
                if (rx.rx_valid && rx.rx_ready)
                    rx.rx_valid <= 1'b0;
                if (byte_done)
                    rx.overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected events, a monitor pops them.
// The parity scenario is compiled only with UART_RX_PARITY_EN.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 434;
    localparam int EV_BYTE  = 0;
    localparam int EV_FERR  = 1;
    localparam int EV_OVR   = 2;
    localparam int EV_PERR  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    int   checks = 0;
    int   errors = 0;
    evt_t sb[$];

    uart_rx_if rx_if ();

    uart_rx #(.clk_freq(50000000), .baud_rate(115200)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .rx  (rx_if)
    );

    always #10 clk = ~clk;

    task automatic push_evt(input int kind, input logic [7:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic pop_evt(input int kind, input logic [7:0] data);
        evt_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind %0d data %02h, expected nothing", kind, data);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || (kind == EV_BYTE && e.data !== data)) begin
                errors++;
                $display("FAIL sb_event: got kind %0d data %02h, expected kind %0d data %02h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every output event is matched against the scoreboard in order.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rx_if.rx_valid && !prev_valid) pop_evt(EV_BYTE, rx_if.rx_data);
                if (rx_if.frame_err)  pop_evt(EV_FERR, 8'h00);
                if (rx_if.overrun)    pop_evt(EV_OVR, 8'h00);
                if (rx_if.parity_err) pop_evt(EV_PERR, 8'h00);
                if (prev_valid && rx_if.rx_valid) begin
                    checks++;
                    if (rx_if.rx_data !== prev_data) begin
                        errors++;
                        $display("FAIL data_stable: got %02h, expected %02h", rx_if.rx_data, prev_data);
                    end
                end
            end
            prev_valid = rx_if.rx_valid;
            prev_data  = rx_if.rx_data;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                              input int idle_bits);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop);
        rxd = 1'b1;
        wait_clk(idle_bits * BIT_CLKS);
    endtask

    task automatic consume(input string name);
        int n;
        n = 0;
        while (!rx_if.rx_valid && n < 20000) begin
            wait_clk(1);
            n++;
        end
        check({name, "_valid_before"}, {7'd0, rx_if.rx_valid}, 8'h01);
        rx_if.rx_ready = 1'b1;
        wait_clk(1);
        rx_if.rx_ready = 1'b0;
        check({name, "_valid_after"}, {7'd0, rx_if.rx_valid}, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.rx_ready = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        check("rst_data", rx_if.rx_data, 8'h00);
        check("rst_valid", {7'd0, rx_if.rx_valid}, 8'h00);
        check("rst_flags", {5'd0, rx_if.frame_err, rx_if.overrun, rx_if.parity_err}, 8'h00);
        wait_clk(20);

        // Test 1: simple byte held until consumed
        push_evt(EV_BYTE, 8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1);
        wait_clk(50);
        check("t1_valid_held", {7'd0, rx_if.rx_valid}, 8'h01);
        check("t1_data", rx_if.rx_data, 8'h55);
        consume("t1");

        // Test 2: short low glitch rejected
        rxd = 1'b0;
        wait_clk(100);
        rxd = 1'b1;
        wait_clk(600);
        check("t2_valid", {7'd0, rx_if.rx_valid}, 8'h00);
        check("t2_state", {5'd0, dut.state}, {5'd0, ST_IDLE});

        // Test 3: framing error, then a good frame
        push_evt(EV_FERR, 8'h00);
        send_frame(8'hA3, 1'b0, 1'b0, 1);
        check("t3_valid_after_ferr", {7'd0, rx_if.rx_valid}, 8'h00);
        push_evt(EV_BYTE, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1);
        check("t3_data", rx_if.rx_data, 8'h3C);
        consume("t3");

        // Test 4: back-to-back with no consumer -> overrun
        push_evt(EV_BYTE, 8'h12);
        push_evt(EV_OVR, 8'h00);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        send_frame(8'h34, 1'b1, 1'b0, 1);
        check("t4_data_kept", rx_if.rx_data, 8'h12);
        consume("t4");

        // Test 5: reset during data bit 4 with a byte pending
        push_evt(EV_BYTE, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rxd = 1'b1;
        wait_clk(200);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("t5_rst_valid", {7'd0, rx_if.rx_valid}, 8'h00);
        check("t5_rst_data", rx_if.rx_data, 8'h00);
        check("t5_rst_flags", {5'd0, rx_if.frame_err, rx_if.overrun, rx_if.parity_err}, 8'h00);
        wait_clk(10 * BIT_CLKS);
        check("t5_idle_valid", {7'd0, rx_if.rx_valid}, 8'h00);
        push_evt(EV_BYTE, 8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0, 1);
        check("t5_data", rx_if.rx_data, 8'hFF);
        consume("t5");

`ifdef UART_RX_PARITY_EN
        // Test 6: bad parity dropped, good parity accepted
        push_evt(EV_PERR, 8'h00);
        send_frame(8'h07, 1'b1, 1'b1, 1);
        check("t6_valid_after_perr", {7'd0, rx_if.rx_valid}, 8'h00);
        push_evt(EV_BYTE, 8'h07);
        send_frame(8'h07, 1'b1, 1'b0, 1);
        check("t6_data", rx_if.rx_data, 8'h07);
        consume("t6");
`endif

        wait_clk(100);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending events, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
